// File: rtl/regfile_scb_if.sv
// Register-file port bundle: write/reserve/clear controls in, read data and status out.
// The master modport is the datapath side; the slave modport is the register file.
interface regfile_scb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
);
    localparam int AW = $clog2(NUM_REGS);

    logic              LD_REG;
    logic [AW-1:0]     DR_MUX;
    logic [DATA_W-1:0] BUS;
    logic              RSV;
    logic [AW-1:0]     RSV_DR;
    logic [AW-1:0]     SR1_MUX;
    logic [AW-1:0]     SR2;
    logic              Clear_Req;
    logic [DATA_W-1:0] SR1_out;
    logic [DATA_W-1:0] SR2_out;
    logic              SR1_rdy;
    logic              SR2_rdy;
    logic [DATA_W-1:0] SR_test;
    logic              Clear_Busy;
    logic              Any_Busy;

    modport master (
        output LD_REG, DR_MUX, BUS, RSV, RSV_DR, SR1_MUX, SR2, Clear_Req,
        input  SR1_out, SR2_out, SR1_rdy, SR2_rdy, SR_test, Clear_Busy, Any_Busy
    );

    modport slave (
        input  LD_REG, DR_MUX, BUS, RSV, RSV_DR, SR1_MUX, SR2, Clear_Req,
        output SR1_out, SR2_out, SR1_rdy, SR2_rdy, SR_test, Clear_Busy, Any_Busy
    );
endinterface

// File: rtl/regfile_scb.sv
// LC-3 general-purpose register file with busy scoreboard and a one-register-per-cycle bulk clear.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto SR1/SR2 reads.
module regfile_scb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int DBG_IDX  = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    regfile_scb_if.slave rf
);
    localparam int            AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] DBG_SEL  = AW'(DBG_IDX);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                idle, wr_en, rsv_en;

    // A clear request in IDLE swallows any write or reserve arriving with it.
    assign idle   = (state_q == IDLE);
    assign wr_en  = idle && !rf.Clear_Req && rf.LD_REG;
    assign rsv_en = idle && !rf.Clear_Req && rf.RSV;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rf.Clear_Req)      state_d = SWEEP;
            SWEEP: if (ptr_q == LAST_IDX) state_d = IDLE;
        endcase
    end

    // NOTE: the array is architecturally visible after reset, so every word is reset here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            ptr_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            ptr_q  <= ptr_d;
        end
    end

    // NOTE: every next-state value gets a default first so no path can infer a latch.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        ptr_d  = ptr_q;
        if (idle && rf.Clear_Req) begin
            busy_d = '0;
            ptr_d  = '0;
        end else if (!idle) begin
            regs_d[ptr_q] = '0;
            ptr_d         = ptr_q + 1'b1;
        end
        if (wr_en) begin
            regs_d[rf.DR_MUX] = rf.BUS;
            busy_d[rf.DR_MUX] = 1'b0;
        end
        // Reserve is applied after the write so a same-register collision leaves it busy.
        if (rsv_en) busy_d[rf.RSV_DR] = 1'b1;
    end

    always_comb begin
        rf.Clear_Busy = (state_q == SWEEP);
        rf.Any_Busy   = |busy_q;
        rf.SR_test    = regs_q[DBG_SEL];
        rf.SR1_out    = regs_q[rf.SR1_MUX];
        rf.SR2_out    = regs_q[rf.SR2];
        rf.SR1_rdy    = !idle || !busy_q[rf.SR1_MUX];
        rf.SR2_rdy    = !idle || !busy_q[rf.SR2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && rf.SR1_MUX == rf.DR_MUX) begin
            rf.SR1_out = rf.BUS;
            rf.SR1_rdy = 1'b1;
        end
        if (wr_en && rf.SR2 == rf.DR_MUX) begin
            rf.SR2_out = rf.BUS;
            rf.SR2_rdy = 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_regfile_scb.sv
// Directed bench for regfile_scb: an 8x16 instance driven from a vector table plus
// hand-written clear/reset/bypass sequences, and a 16x32 instance for parametrisation.
module tb_regfile_scb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cnt;

    regfile_scb_if #(.DATA_W(16), .NUM_REGS(8))  rf0 ();
    regfile_scb_if #(.DATA_W(32), .NUM_REGS(16)) rf1 ();

    regfile_scb #(.DATA_W(16), .NUM_REGS(8), .DBG_IDX(1)) u_dut0 (
        .Clk(clk), .Reset(rst0), .rf(rf0.slave)
    );
    regfile_scb #(.DATA_W(32), .NUM_REGS(16), .DBG_IDX(1)) u_dut1 (
        .Clk(clk), .Reset(rst1), .rf(rf1.slave)
    );

    typedef struct {
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] bus;
        logic        rsv;
        logic [2:0]  rsv_dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [15:0] e1;
        logic        r1;
        logic [15:0] e2;
        logic        r2;
        logic        any;
        logic [15:0] test;
    } vec_t;

    vec_t vec [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            ld dr  bus      rsv rdr sr1 sr2  e1       r1  e2       r2  any test
        vec[0]  = '{1, 3, 16'hBEEF, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1, 0, 16'h0000};
        vec[1]  = '{0, 0, 16'h0000, 0, 0, 3, 0, 16'hBEEF, 1, 16'h0000, 1, 0, 16'h0000};
        vec[2]  = '{1, 1, 16'h1234, 0, 0, 3, 3, 16'hBEEF, 1, 16'hBEEF, 1, 0, 16'h0000};
        vec[3]  = '{0, 0, 16'h0000, 0, 0, 1, 3, 16'h1234, 1, 16'hBEEF, 1, 0, 16'h1234};
        vec[4]  = '{0, 0, 16'h0000, 1, 2, 2, 1, 16'h0000, 1, 16'h1234, 1, 0, 16'h1234};
        vec[5]  = '{0, 0, 16'h0000, 0, 0, 2, 2, 16'h0000, 0, 16'h0000, 0, 1, 16'h1234};
        vec[6]  = '{1, 2, 16'h0042, 0, 0, 3, 1, 16'hBEEF, 1, 16'h1234, 1, 1, 16'h1234};
        vec[7]  = '{0, 0, 16'h0000, 0, 0, 2, 2, 16'h0042, 1, 16'h0042, 1, 0, 16'h1234};
        vec[8]  = '{1, 2, 16'h0077, 1, 2, 3, 1, 16'hBEEF, 1, 16'h1234, 1, 0, 16'h1234};
        vec[9]  = '{0, 0, 16'h0000, 0, 0, 2, 0, 16'h0077, 0, 16'h0000, 1, 1, 16'h1234};
        vec[10] = '{1, 6, 16'h0606, 1, 4, 2, 5, 16'h0077, 0, 16'h0000, 1, 1, 16'h1234};
        vec[11] = '{0, 0, 16'h0000, 0, 0, 4, 6, 16'h0000, 0, 16'h0606, 1, 1, 16'h1234};
        vec[12] = '{1, 4, 16'h4444, 0, 0, 2, 1, 16'h0077, 0, 16'h1234, 1, 1, 16'h1234};
        vec[13] = '{1, 2, 16'h2222, 0, 0, 4, 6, 16'h4444, 1, 16'h0606, 1, 1, 16'h1234};
        vec[14] = '{0, 0, 16'h0000, 0, 0, 2, 4, 16'h2222, 1, 16'h4444, 1, 0, 16'h1234};

        rf0.LD_REG = 0; rf0.DR_MUX = 0; rf0.BUS = 0; rf0.RSV = 0; rf0.RSV_DR = 0;
        rf0.SR1_MUX = 0; rf0.SR2 = 0; rf0.Clear_Req = 0;
        rf1.LD_REG = 0; rf1.DR_MUX = 0; rf1.BUS = 0; rf1.RSV = 0; rf1.RSV_DR = 0;
        rf1.SR1_MUX = 0; rf1.SR2 = 0; rf1.Clear_Req = 0;
        rst0 = 1; rst1 = 1;
        tick();
        rst0 = 0; rst1 = 0;

        // Reset state
        for (int i = 0; i < 8; i++) begin
            rf0.SR1_MUX = 3'(i); rf0.SR2 = 3'(7 - i);
            #1;
            check($sformatf("rst sr1 r%0d", i), rf0.SR1_out, 16'h0);
            check($sformatf("rst sr2 r%0d", 7 - i), rf0.SR2_out, 16'h0);
            check($sformatf("rst rdy r%0d", i), {rf0.SR1_rdy, rf0.SR2_rdy}, 2'b11);
        end
        check("rst clear_busy", rf0.Clear_Busy, 1'b0);
        check("rst any_busy", rf0.Any_Busy, 1'b0);
        check("rst sr_test", rf0.SR_test, 16'h0);

        // Vector table: inputs applied for one cycle, outputs checked before the edge
        for (int i = 0; i < 15; i++) begin
            rf0.LD_REG = vec[i].ld; rf0.DR_MUX = vec[i].dr; rf0.BUS = vec[i].bus;
            rf0.RSV = vec[i].rsv; rf0.RSV_DR = vec[i].rsv_dr;
            rf0.SR1_MUX = vec[i].sr1; rf0.SR2 = vec[i].sr2;
            #1;
            check($sformatf("v%0d sr1_out", i), rf0.SR1_out, vec[i].e1);
            check($sformatf("v%0d sr1_rdy", i), rf0.SR1_rdy, vec[i].r1);
            check($sformatf("v%0d sr2_out", i), rf0.SR2_out, vec[i].e2);
            check($sformatf("v%0d sr2_rdy", i), rf0.SR2_rdy, vec[i].r2);
            check($sformatf("v%0d any_busy", i), rf0.Any_Busy, vec[i].any);
            check($sformatf("v%0d sr_test", i), rf0.SR_test, vec[i].test);
            tick();
        end
        rf0.LD_REG = 0; rf0.RSV = 0;

        // Bypass: R5 reserved, then written while SR2 reads it
        rf0.RSV = 1; rf0.RSV_DR = 5;
        tick();
        rf0.RSV = 0;
        rf0.LD_REG = 1; rf0.DR_MUX = 5; rf0.BUS = 16'hA5A5; rf0.SR1_MUX = 3; rf0.SR2 = 5;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp sr2_out", rf0.SR2_out, 16'hA5A5);
        check("byp sr2_rdy", rf0.SR2_rdy, 1'b1);
`else
        check("byp sr2_out", rf0.SR2_out, 16'h0000);
        check("byp sr2_rdy", rf0.SR2_rdy, 1'b0);
`endif
        check("byp sr1_out", rf0.SR1_out, 16'hBEEF);
        tick();
        rf0.LD_REG = 0;
        #1;
        check("byp after sr2_out", rf0.SR2_out, 16'hA5A5);
        check("byp after sr2_rdy", rf0.SR2_rdy, 1'b1);

        // SR_test never forwards
        rf0.LD_REG = 1; rf0.DR_MUX = 1; rf0.BUS = 16'hDEAD;
        #1;
        check("sr_test no bypass", rf0.SR_test, 16'h1234);
        tick();
        rf0.LD_REG = 0;
        #1;
        check("sr_test updated", rf0.SR_test, 16'hDEAD);

        // Bulk clear: preload, reserve R4, clear with a colliding write and reserve
        for (int i = 0; i < 8; i++) begin
            rf0.LD_REG = 1; rf0.DR_MUX = 3'(i); rf0.BUS = 16'h1000 + 16'(i);
            tick();
        end
        rf0.LD_REG = 0; rf0.RSV = 1; rf0.RSV_DR = 4;
        tick();
        rf0.RSV = 0; rf0.SR1_MUX = 4;
        #1;
        check("pre-clr r4 rdy", rf0.SR1_rdy, 1'b0);
        check("pre-clr any_busy", rf0.Any_Busy, 1'b1);
        rf0.Clear_Req = 1; rf0.LD_REG = 1; rf0.DR_MUX = 0; rf0.BUS = 16'hFFFF;
        rf0.RSV = 1; rf0.RSV_DR = 0;
        tick();
        rf0.Clear_Req = 0; rf0.LD_REG = 0; rf0.RSV = 0; rf0.SR2 = 0;
        #1;
        check("clr0 clear_busy", rf0.Clear_Busy, 1'b1);
        check("clr0 any_busy", rf0.Any_Busy, 1'b0);
        check("clr0 r4 data", rf0.SR1_out, 16'h1004);
        check("clr0 r4 rdy", rf0.SR1_rdy, 1'b1);
        check("clr0 r0 write dropped", rf0.SR2_out, 16'h1000);
        rf0.SR1_MUX = 7;
        cnt = 0;
        for (int c = 0; c < 40 && rf0.Clear_Busy; c++) begin
            cnt++;
            if (cnt == 4) begin
                check("sweep r0 zeroed", rf0.SR2_out, 16'h0);
                check("sweep r7 old", rf0.SR1_out, 16'h1007);
                check("sweep rdy", {rf0.SR1_rdy, rf0.SR2_rdy}, 2'b11);
            end
            rf0.LD_REG = (cnt == 3); rf0.DR_MUX = 0; rf0.BUS = 16'hBAD1;
            tick();
        end
        rf0.LD_REG = 0;
        check("clr0 busy cycles", cnt, 8);
        for (int i = 0; i < 8; i++) begin
            rf0.SR1_MUX = 3'(i);
            #1;
            check($sformatf("post-clr r%0d", i), rf0.SR1_out, 16'h0);
        end
        check("post-clr any_busy", rf0.Any_Busy, 1'b0);

        // Reset in sweep cycle 3
        rf0.LD_REG = 1; rf0.DR_MUX = 7; rf0.BUS = 16'h7777;
        tick();
        rf0.LD_REG = 0; rf0.Clear_Req = 1;
        tick();
        rf0.Clear_Req = 0;
        tick(); tick(); tick();
        rf0.SR1_MUX = 7;
        #1;
        check("mid-sweep clear_busy", rf0.Clear_Busy, 1'b1);
        check("mid-sweep r7 old", rf0.SR1_out, 16'h7777);
        rst0 = 1;
        tick();
        rst0 = 0;
        #1;
        check("abort clear_busy", rf0.Clear_Busy, 1'b0);
        check("abort r7", rf0.SR1_out, 16'h0);
        check("abort rdy", rf0.SR1_rdy, 1'b1);

        // 16x32 instance
        rf1.SR1_MUX = 15; rf1.SR2 = 3;
        #1;
        check("w32 rst r15", rf1.SR1_out, 32'h0);
        check("w32 rst clear_busy", rf1.Clear_Busy, 1'b0);
        rf1.LD_REG = 1; rf1.DR_MUX = 3; rf1.BUS = 32'hDEADBEEF;
        tick();
        rf1.DR_MUX = 1; rf1.BUS = 32'h12345678; rf1.SR1_MUX = 3;
        #1;
        check("w32 r3 readback", rf1.SR1_out, 32'hDEADBEEF);
        tick();
        rf1.LD_REG = 0;
        #1;
        check("w32 sr_test", rf1.SR_test, 32'h12345678);
        for (int i = 0; i < 16; i++) begin
            rf1.LD_REG = 1; rf1.DR_MUX = 4'(i); rf1.BUS = 32'hA0000000 + 32'(i);
            tick();
        end
        rf1.LD_REG = 0; rf1.SR1_MUX = 15;
        #1;
        check("w32 preload r15", rf1.SR1_out, 32'hA000000F);
        rf1.Clear_Req = 1;
        tick();
        rf1.Clear_Req = 0;
        cnt = 0;
        for (int c = 0; c < 60 && rf1.Clear_Busy; c++) begin
            cnt++;
            tick();
        end
        check("w32 clr busy cycles", cnt, 16);
        for (int i = 0; i < 16; i++) begin
            rf1.SR1_MUX = 4'(i);
            #1;
            check($sformatf("w32 post-clr r%0d", i), rf1.SR1_out, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
